jpeg_seq_ctrl: RTL and testbench

Parametrised frame sequencer for the JPEG pipeline. It drives the input-memory read address, the two ping-pong transpose/zig-zag bank selects, the RLE enable and the output-memory write address/strobe from a single frame timer. Run length, block size, pipeline delays and bank-toggle phases are all set by parameters. A start/stall/done handshake and an optional continuous-frame mode replace the earlier free-running counters.

---
 rtl/jpeg_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_jpeg_seq_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_seq_ctrl.sv
// jpeg_seq_ctrl: frame sequencer for the JPEG pipeline.
// A single frame timer t drives the input read address, the transpose/zig-zag
// bank selects, the RLE enable and the output write address/strobe.
// Optional macro SEQ_CONT_EN: continuous-frame mode (t wraps every N rows,
// done pulses on each write of the last output row, IDLE only via reset).
module jpeg_seq_ctrl #(
    parameter int ADDR_W     = 15,
    parameter int ROW_W      = 3,
    parameter int NUM_BLOCKS = 4096,
    parameter int OUT_DLY    = 20,
    parameter int RLE_DLY    = 19,
    parameter int TP1_PHASE  = 0,
    parameter int TP2_PHASE  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    output logic              in_re,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ROW_W-1:0]  in_row,
    output logic              tp1_sel,
    output logic              tp2_sel,
    output logic              rle_en,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);
    localparam int ROWS = 2 ** ROW_W;
    localparam int N    = NUM_BLOCKS * ROWS;
    localparam int TW   = ADDR_W + 1;

    localparam logic [TW-1:0]     N_T      = TW'(N);
    localparam logic [TW-1:0]     OUT_T    = TW'(OUT_DLY);
    localparam logic [TW-1:0]     RLE_T    = TW'(RLE_DLY);
    localparam logic [TW-1:0]     OUT_END  = TW'(OUT_DLY + N);
    localparam logic [TW-1:0]     RLE_END  = TW'(RLE_DLY + N);
    localparam logic [TW-1:0]     T_LAST   = TW'(OUT_DLY + N - 1);
    localparam logic [TW-1:0]     T_WRAP   = TW'(N - 1);
    localparam logic [ADDR_W-1:0] A_LAST   = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] A_OUTDLY = ADDR_W'(OUT_DLY);
    localparam logic [ADDR_W-1:0] A_WRAPOF = ADDR_W'(N - OUT_DLY);
    localparam logic [ROW_W:0]    PH1      = (ROW_W+1)'(TP1_PHASE);
    localparam logic [ROW_W:0]    PH2      = (ROW_W+1)'(TP2_PHASE);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] t, t_nx;
    logic [ROW_W:0] d1, d2;
`ifdef SEQ_CONT_EN
    // Set once the first frame has wrapped; from then on the pipe is full.
    logic wrapped, wrapped_nx;
`endif

    // State, timer and fill flag; stall simply leaves next == current.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            t     <= '0;
`ifdef SEQ_CONT_EN
            wrapped <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            t     <= t_nx;
`ifdef SEQ_CONT_EN
            wrapped <= wrapped_nx;
`endif
        end
    end

    // Next-state: start only accepted in IDLE, timer advances on non-stalled RUN cycles.
    always_comb begin
        state_nx = state;
        t_nx     = t;
`ifdef SEQ_CONT_EN
        wrapped_nx = wrapped;
`endif
        case (state)
            IDLE: if (start) begin
                state_nx = RUN;
                t_nx     = '0;
            end
            RUN: if (!stall) begin
`ifdef SEQ_CONT_EN
                if (t == T_WRAP) begin
                    t_nx       = '0;
                    wrapped_nx = 1'b1;
                end else begin
                    t_nx = t + 1'b1;
                end
`else
                if (t == T_LAST) begin
                    state_nx = DONE;
                    t_nx     = '0;
                end else begin
                    t_nx = t + 1'b1;
                end
`endif
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign d1 = t[ROW_W:0] - PH1;
    assign d2 = t[ROW_W:0] - PH2;

    // Output decode from the registered state; only the strobes see stall directly.
    always_comb begin
        in_re    = 1'b0;
        in_addr  = '0;
        tp1_sel  = 1'b1;
        tp2_sel  = 1'b1;
        rle_en   = 1'b0;
        out_we   = 1'b0;
        out_addr = '0;
        busy     = (state == RUN);
        done     = 1'b0;
        if (state == RUN) begin
            tp1_sel = ~d1[ROW_W];
            tp2_sel = ~d2[ROW_W];
`ifdef SEQ_CONT_EN
            in_re   = ~stall;
            in_addr = t[ADDR_W-1:0];
            rle_en  = wrapped | (t >= RLE_T);
            if (wrapped | (t >= OUT_T)) begin
                out_we   = ~stall;
                out_addr = (t >= OUT_T) ? (t[ADDR_W-1:0] - A_OUTDLY)
                                        : (t[ADDR_W-1:0] + A_WRAPOF);
            end
            done = out_we & (out_addr == A_LAST);
`else
            in_re   = (t < N_T) & ~stall;
            in_addr = (t < N_T) ? t[ADDR_W-1:0] : A_LAST;
            rle_en  = (t >= RLE_T) & (t < RLE_END);
            if ((t >= OUT_T) && (t < OUT_END)) begin
                out_we   = ~stall;
                out_addr = t[ADDR_W-1:0] - A_OUTDLY;
            end
`endif
        end
`ifndef SEQ_CONT_EN
        done = (state == DONE);
`endif
    end

    assign in_row = in_addr[ROW_W-1:0];

endmodule

// File: tb/tb_jpeg_seq_ctrl.sv
// Bench for jpeg_seq_ctrl: directed scenarios plus randomized stall/start,
// every cycle compared against a frame-level model of the sequencer.
module tb_jpeg_seq_ctrl;
    localparam int ADDR_W = 15, ROW_W = 3, NUM_BLOCKS = 4;
    localparam int OUT_DLY = 20, RLE_DLY = 19, TP1 = 0, TP2 = 2;
    localparam int ROWS = 2 ** ROW_W;
    localparam int N = NUM_BLOCKS * ROWS;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, stall = 1'b0;
    logic in_re, tp1_sel, tp2_sel, rle_en, out_we, busy, done;
    logic [ADDR_W-1:0] in_addr, out_addr;
    logic [ROW_W-1:0] in_row;

    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    jpeg_seq_ctrl #(.ADDR_W(ADDR_W), .ROW_W(ROW_W), .NUM_BLOCKS(NUM_BLOCKS),
                    .OUT_DLY(OUT_DLY), .RLE_DLY(RLE_DLY),
                    .TP1_PHASE(TP1), .TP2_PHASE(TP2)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .in_re(in_re), .in_addr(in_addr), .in_row(in_row),
        .tp1_sel(tp1_sel), .tp2_sel(tp2_sel), .rle_en(rle_en),
        .out_we(out_we), .out_addr(out_addr), .busy(busy), .done(done));

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (time %0t)", nm, act, exp, $time);
    endtask

    // Model: mode 0 idle, 1 running, 2 frame complete; mt = rows elapsed.
    int mst = 0, mt = 0;
    bit mwrap = 0;
    always @(posedge clk) begin
        if (!reset) begin
            mst = 0; mt = 0; mwrap = 0;
        end else begin
            case (mst)
                0: if (start) begin mst = 1; mt = 0; end
                1: if (!stall) begin
`ifdef SEQ_CONT_EN
                    if (mt == N - 1) begin mt = 0; mwrap = 1; end
                    else mt++;
`else
                    if (mt == OUT_DLY + N - 1) mst = 2;
                    else mt++;
`endif
                end
                default: mst = 0;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit run, e_re, e_we, e_rle, e_done;
        int e_ia, e_oa;
        run = (mst == 1);
`ifdef SEQ_CONT_EN
        e_re   = run && !stall;
        e_ia   = mt;
        e_we   = run && (mwrap || mt >= OUT_DLY) && !stall;
        e_oa   = (mwrap || mt >= OUT_DLY) ? (mt - OUT_DLY + N) % N : 0;
        e_rle  = run && (mwrap || mt >= RLE_DLY);
        e_done = e_we && (e_oa == N - 1);
`else
        e_re   = run && mt < N && !stall;
        e_ia   = (mt < N) ? mt : N - 1;
        e_we   = run && mt >= OUT_DLY && mt < OUT_DLY + N && !stall;
        e_oa   = (mt >= OUT_DLY && mt < OUT_DLY + N) ? mt - OUT_DLY : 0;
        e_rle  = run && mt >= RLE_DLY && mt < RLE_DLY + N;
        e_done = (mst == 2);
`endif
        chk("in_re", in_re, e_re);
        chk("out_we", out_we, e_we);
        chk("rle_en", rle_en, e_rle);
        chk("busy", busy, run);
        chk("done", done, e_done);
        chk("tp1_sel", tp1_sel, run ? (((mt + 2*ROWS - TP1) % (2*ROWS)) < ROWS) : 1);
        chk("tp2_sel", tp2_sel, run ? (((mt + 2*ROWS - TP2) % (2*ROWS)) < ROWS) : 1);
        if (run) begin
            chk("in_addr", in_addr, e_ia);
            chk("in_row", in_row, e_ia % ROWS);
            chk("out_addr", out_addr, e_oa);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until done is seen; c = edges taken. Bounded.
    task automatic run_to_done(output int c);
        c = 0;
        while (!done && c < 400) begin step(); c++; end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int c, k, stalls;
        reset = 1'b0;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_tp1", tp1_sel, 1);
        chk("rst_tp2", tp2_sel, 1);
        chk("rst_we", out_we, 0);
        reset = 1'b1;
        step();
`ifdef SEQ_CONT_EN
        start = 1'b1; step(); start = 1'b0;
        chk("c_first_addr", in_addr, 0);
        repeat (31) step();
        chk("c_addr31", in_addr, 31);
        step();
        chk("c_wrap_addr", in_addr, 0);
        chk("c_wrap_we", out_we, 1);
        c = 0;
        for (int i = 0; i < 300; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            start = ($urandom_range(0, 7) == 0);
            #1;
            if (done) begin c++; chk("c_done_addr", out_addr, 31); end
            chk("c_busy", busy, 1);
            step();
        end
        stall = 1'b0; start = 1'b0;
        chk("c_done_seen", c > 3, 1);
`else
        // 1: plain frame with literal timing points
        start = 1'b1; step(); start = 1'b0;
        chk("s1_first_re", in_re, 1);
        chk("s1_first_addr", in_addr, 0);
        c = 0;
        for (k = 0; k < 60 && !done; k++) begin
            if (k == 0)  chk("s1_tp2_t0", tp2_sel, 0);
            if (k == 2)  chk("s1_tp2_t2", tp2_sel, 1);
            if (k == 8)  chk("s1_tp1_t8", tp1_sel, 0);
            if (k == 18) chk("s1_rle_t18", rle_en, 0);
            if (k == 19) chk("s1_rle_t19", rle_en, 1);
            if (k == 20) chk("s1_we_t20", out_we, 1);
            if (k == 31) chk("s1_addr_t31", in_addr, 31);
            if (k == 32) chk("s1_re_t32", in_re, 0);
            if (k == 51) chk("s1_oaddr_t51", out_addr, 31);
            step(); c++;
        end
        chk("s1_frame_len", c, 52);
        step();
        chk("s1_idle_busy", busy, 0);
        // 3: three stall cycles at t=10
        start = 1'b1; step(); start = 1'b0;
        repeat (10) step();
        stall = 1'b1;
        repeat (3) begin
            #1;
            chk("s3_stall_re", in_re, 0);
            chk("s3_stall_addr", in_addr, 10);
            step();
        end
        stall = 1'b0;
        run_to_done(c);
        chk("s3_frame_len", 13 + c, 55);
        step();
        // 4: reset mid-frame
        start = 1'b1; step(); start = 1'b0;
        repeat (25) step();
        reset = 1'b0; step();
        chk("s4_busy", busy, 0);
        chk("s4_we", out_we, 0);
        chk("s4_tp1", tp1_sel, 1);
        chk("s4_done", done, 0);
        reset = 1'b1; step();
        chk("s4_no_done", done, 0);
        start = 1'b1; step(); start = 1'b0;
        chk("s4_restart_addr", in_addr, 0);
        run_to_done(c);
        chk("s4_frame_len", c, 52);
        step();
        // 5: start while busy ignored; start+stall in IDLE accepted
        start = 1'b1; step(); start = 1'b0;
        repeat (5) step();
        start = 1'b1; step(); start = 1'b0;
        run_to_done(c);
        chk("s5_frame_len", 6 + c, 52);
        step();
        start = 1'b1; stall = 1'b1; step(); start = 1'b0; stall = 1'b0;
        chk("s5_ss_busy", busy, 1);
        chk("s5_ss_addr", in_addr, 0);
        run_to_done(c);
        chk("s5_ss_len", c, 52);
        step();
        // random frames
        repeat (8) begin
            start = 1'b1; step(); start = 1'b0;
            c = 0; stalls = 0;
            while (!done && c < 500) begin
                stall = ($urandom_range(0, 3) == 0);
                start = ($urandom_range(0, 7) == 0);
                if (stall) stalls++;
                step(); c++;
            end
            stall = 1'b0; start = 1'b0;
            chk("rand_frame_len", c, 52 + stalls);
            step();
            repeat ($urandom_range(0, 3)) step();
        end
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
